// File: rtl/uart_rx_mmio_if.sv
// CPU load/store I/O bus for the UART receive responder.
//   bus_addr    : byte address from the execute stage
//   bus_re      : load strobe, valid with bus_addr
//   bus_we      : store strobe, valid with bus_addr
//   bus_wr_data : store data, low byte
//   rd_data     : registered read data, valid the cycle after the load
interface uart_rx_mmio_if;
  logic [31:0] bus_addr;
  logic        bus_re;
  logic        bus_we;
  logic [7:0]  bus_wr_data;
  logic [31:0] rd_data;

  modport master (
    output bus_addr, bus_re, bus_we, bus_wr_data,
    input  rd_data
  );

  modport slave (
    input  bus_addr, bus_re, bus_we, bus_wr_data,
    output rd_data
  );
endinterface

// File: rtl/uart_rx_mmio.sv
// Memory-mapped UART receiver: deserialises 8N1 frames into a FIFO and
// answers CPU loads of the data (pop) and status addresses; stores to the
// status address clear error flags or flush the FIFO.
//   clk     : system clock
//   rst     : synchronous reset, active-high
//   uart_rx : asynchronous serial input, idle high
//   bus     : CPU load/store port (slave side)
//   irq     : FIFO not empty (registered)
//   rx_busy : receive FSM not idle
module uart_rx_mmio #(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] DATA_ADDR    = 32'h2000_0100,
  parameter logic [31:0] STATUS_ADDR  = 32'h2000_0104
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rx,
  uart_rx_mmio_if.slave        bus,
  output logic                 irq,
  output logic                 rx_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_FULL   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // Receiver state
  logic          r_sync1, r_sync2, r_prev;
  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_idx, w_idx_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          w_start, w_push, w_frame_set;

  // FIFO and flags
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wp, r_rp, w_wp_nxt, w_rp_nxt, w_count;
  logic          w_empty, w_full, w_pop, w_flush, w_push_ok, w_ovr_set;
  logic          r_overrun, r_frame_err, r_irq;
  logic          w_hit_data, w_hit_stat, w_store;
  logic [31:0]   w_status, w_rd_nxt, r_rd_data;
  logic          w_unused;

  assign w_unused = ^{bus.bus_wr_data[7:4], bus.bus_wr_data[1]};

  // Previous-sample flop resets to 0 so a line held low through reset
  // must go high before a start edge can be seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= uart_rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_start = r_prev & ~r_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_push      = 1'b0;
    w_frame_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_start) w_state_nxt = S_START;
      end
      S_START: begin
        if (r_cnt == C_HALF) begin
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_state_nxt = r_sync2 ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt == C_FULL) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {r_sync2, r_shift[7:1]};
          w_idx_nxt   = r_idx + 3'd1;
          if (r_idx == 3'd7) w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (r_cnt == C_FULL) begin
          w_cnt_nxt   = '0;
          w_push      = r_sync2;
          w_frame_set = ~r_sync2;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign rx_busy = (r_state != S_IDLE);

  // FIFO control. Pop (or flush) frees space before the push is judged,
  // so a push on the same edge as a pop/flush of a full FIFO is kept.
  assign w_count    = r_wp - r_rp;
  assign w_empty    = (w_count == '0);
  assign w_full     = (w_count == FULL_CNT);
  assign w_hit_data = (bus.bus_addr == DATA_ADDR);
  assign w_hit_stat = (bus.bus_addr == STATUS_ADDR);
  assign w_pop      = bus.bus_re & w_hit_data & ~w_empty;
  assign w_store    = bus.bus_we & ~bus.bus_re & w_hit_stat;
  assign w_flush    = w_store & bus.bus_wr_data[0];
  assign w_push_ok  = w_push & (~w_full | w_pop | w_flush);
  assign w_ovr_set  = w_push & ~w_push_ok;
  assign w_rp_nxt   = w_flush ? r_wp : (w_pop ? r_rp + (AW + 1)'(1) : r_rp);
  assign w_wp_nxt   = w_push_ok ? r_wp + (AW + 1)'(1) : r_wp;

  always_comb begin
    w_status            = '0;
    w_status[0]         = ~w_empty;
    w_status[1]         = w_full;
    w_status[2]         = r_overrun;
    w_status[3]         = r_frame_err;
    w_status[8 +: AW+1] = w_count;
  end

  always_comb begin
    w_rd_nxt = r_rd_data;
    if (bus.bus_re) begin
      if (w_hit_data)
        w_rd_nxt = w_empty ? '0 : {23'd0, 1'b1, r_mem[r_rp[AW-1:0]]};
      else if (w_hit_stat)
        w_rd_nxt = w_status;
      else
        w_rd_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wp[AW-1:0]] <= r_shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_irq       <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      r_wp      <= w_wp_nxt;
      r_rp      <= w_rp_nxt;
      r_irq     <= (w_wp_nxt != w_rp_nxt);
      r_rd_data <= w_rd_nxt;
      if (w_ovr_set)                          r_overrun <= 1'b1;
      else if (w_store && bus.bus_wr_data[2]) r_overrun <= 1'b0;
      if (w_frame_set)                          r_frame_err <= 1'b1;
      else if (w_store && bus.bus_wr_data[3])   r_frame_err <= 1'b0;
    end
  end

  assign irq         = r_irq;
  assign bus.rd_data = r_rd_data;

endmodule

// File: doc/uart_rx_mmio.md
Name: uart_rx_mmio

Overview:
- Memory-mapped UART receive responder on the CPU load/store I/O path.
- Deserialises 8N1 frames from the serial line and buffers the bytes in a FIFO.
- Answers CPU loads of its data and status addresses. Read data is registered and appears in the cycle after the load is presented, which matches the CPU's write-back timing.
- Supports stores to the status address that clear error flags or flush the FIFO.

Parameters:
- CLKS_PER_BIT, 434: clock cycles per serial bit (50 MHz / 115200); must be ≥ 4.
- FIFO_DEPTH, 8: FIFO entries; power of two, 2..256.
- DATA_ADDR, 32'h2000_0100: load here pops one byte.
- STATUS_ADDR, 32'h2000_0104: status read and control write.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- uart_rx  in  1  asynchronous serial input; idle high
- bus_addr  in  32  byte address from the execute stage
- bus_re  in  1  load strobe, valid with bus_addr
- bus_we  in  1  store strobe, valid with bus_addr
- bus_wr_data  in  8  store data, low byte
- rd_data  out  32  registered read data
- irq  out  1  FIFO not empty (registered)
- rx_busy  out  1  receive FSM not IDLE

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high.
- On rst:
  - rd_data=0, irq=0, rx_busy=0.
  - FIFO empty; overrun=0, frame_err=0; FSM IDLE.
  - Synchroniser flops = 1; previous-sample flop = 0.
  - rst mid-frame abandons the frame and drops any partial byte.
- Input: two-flop synchroniser on uart_rx. Start detect requires previous synced sample = 1 and current = 0. A line held low through reset is therefore never a start; it must go high first.
- FSM (counter `cnt`, bit index `idx`):
  - IDLE: on start edge → START, cnt=0.
  - START: at cnt = CLKS_PER_BIT/2 − 1, sample the line. If 1 (glitch) → IDLE with no flags set. If 0 → DATA, cnt=0, idx=0.
  - DATA: sample when cnt = CLKS_PER_BIT − 1, then reset cnt. Bits are shifted in LSB first. After idx=7 → STOP.
  - STOP: sample at cnt = CLKS_PER_BIT − 1.
    - Sampled 1: push the byte.
    - Sampled 0: set frame_err and discard the byte.
    - In both cases → IDLE in the next cycle, so back-to-back frames are received.
- FIFO:
  - Read/write pointers of width log2(FIFO_DEPTH)+1; count = wp − rp.
  - A push when full is dropped and sets overrun.
  - Pop is evaluated first: a push with a simultaneous pop while full is accepted; count stays FIFO_DEPTH.
  - Pop when empty is a no-op. A simultaneous push into an empty FIFO is accepted, with no bypass to the pop.
- Load of DATA_ADDR (bus_re=1):
  - Next cycle rd_data = {23'd0, 1'b1, head_byte} and the head is popped if non-empty.
  - Otherwise rd_data = 32'd0.
- Load of STATUS_ADDR:
  - Next cycle rd_data fields: bit0 = not_empty, bit1 = full, bit2 = overrun, bit3 = frame_err.
  - Bits [8+log2(FIFO_DEPTH):8] = count; all other bits 0.
  - Status reflects state before any same-edge push.
- Load of any other address: rd_data = 0 next cycle. rd_data holds its value when bus_re=0.
- Store to STATUS_ADDR:
  - bus_wr_data bit2=1 clears overrun; bit3=1 clears frame_err; bit0=1 flushes the FIFO (rp ← wp).
  - A same-cycle set event wins over clear.
  - A push in the same cycle as a flush is retained, leaving count=1.
- Stores to DATA_ADDR or other addresses are ignored.
- bus_re and bus_we both asserted: the load is serviced and the store is ignored.
- irq = registered not_empty after the edge's push/pop/flush. rx_busy = (state ≠ IDLE), combinational from the state register.

Test Plan (bench uses CLKS_PER_BIT=8, FIFO_DEPTH=4):
- Reset, then send frame 0xA5 → rx_busy high for about 78 cycles; irq=1 after the stop sample. Load DATA_ADDR → next cycle rd_data=0x0000_01A5, irq=0. A second load → rd_data=0.
- Send 0x11, 0x22, 0x33, 0x44, 0x55 back-to-back without popping → status reads count=4, full=1, overrun=1. Four pops return 0x111, 0x122, 0x133, 0x144. Store 0x04 to STATUS_ADDR → overrun=0.
- Frame with stop bit 0 (data 0x3C) → FIFO stays empty; status bit3=1. Store 0x08 → status=0. A 2-cycle low glitch on uart_rx → no push, no flags, FSM back in IDLE.
- FIFO full with a DATA_ADDR pop on the same edge as a stop-bit push → pop returns the oldest byte; count remains 4; overrun stays 0.
- Assert rst at DATA bit 4 of a frame while the FIFO holds 2 bytes → after reset, status=0, rd_data=0, irq=0. The next complete frame 0x5A is received correctly.
- Store 0x01 (flush) with 3 bytes queued → count=0, irq=0 next cycle. Load of an unmapped address → rd_data=0.
